// File: rtl/gamepad_pmod_pkg.sv
// Shared definitions for the gamepad PMOD transmitter and receiver.
// Button bit positions within one controller's 12-bit field, plus the TX state encoding.
package gamepad_pmod_pkg;

  localparam int BTN_PER_CTRL = 12;

  localparam int BTN_B      = 11;
  localparam int BTN_Y      = 10;
  localparam int BTN_SELECT = 9;
  localparam int BTN_START  = 8;
  localparam int BTN_UP     = 7;
  localparam int BTN_DOWN   = 6;
  localparam int BTN_LEFT   = 5;
  localparam int BTN_RIGHT  = 4;
  localparam int BTN_A      = 3;
  localparam int BTN_X      = 2;
  localparam int BTN_L      = 1;
  localparam int BTN_R      = 0;

  typedef enum logic [2:0] {IDLE, LOW, HIGH, LATCH, GAP} tx_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gamepad_pmod_tx_tick.sv
// Reloadable down-counter; tc is high while the count sits at zero, so a load of N-1
// gives a phase that lasts exactly N cycles.
module pmod_tick_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/gamepad_pmod_tx.sv
// Gamepad PMOD serializer: snapshots buttons, shifts them out MSB first on data/clk,
// then strobes latch. pmod_data is the MSB of the shift register, which is empty after a frame.
module gamepad_pmod_tx
  import gamepad_pmod_pkg::*;
#(
  parameter int NUM_CTRL  = 1,
  parameter int HALF_DIV  = 4,
  parameter int LATCH_CYC = 4,
  parameter int GAP_CYC   = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [BTN_PER_CTRL*NUM_CTRL-1:0] buttons,
  input  logic                             auto_en,
  input  logic                             start,
  output logic                             pmod_data,
  output logic                             pmod_clk,
  output logic                             pmod_latch,
  output logic                             busy,
  output logic                             frame_done
);

  localparam int NBITS = BTN_PER_CTRL * NUM_CTRL;
  localparam int CW    = $clog2(max3(HALF_DIV, LATCH_CYC, GAP_CYC) + 1);
  localparam int BW    = $clog2(NBITS);

  localparam logic [CW-1:0] HALF_LD  = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] LATCH_LD = CW'(LATCH_CYC - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

  tx_state_t        state;
  logic [NBITS-1:0] shift_reg;
  logic [BW-1:0]    bit_cnt;
  logic             go;
  logic             last_bit;
  logic             load;
  logic [CW-1:0]    load_val;
  logic [CW-1:0]    count;
  logic             tc;

  assign go        = start | auto_en;
  assign last_bit  = (bit_cnt == '0);
  assign pmod_data = shift_reg[NBITS-1];

  // The counter is reloaded on every state transition with the length of the next phase.
  always_comb begin
    load     = 1'b0;
    load_val = HALF_LD;
    case (state)
      IDLE:  load = go;
      HIGH: begin
        load = tc;
        if (last_bit) load_val = LATCH_LD;
      end
      LATCH: begin
        load     = tc;
        load_val = GAP_LD;
      end
      default: load = tc;
    endcase
  end

  pmod_tick_counter #(.W(CW)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      pmod_clk   <= 1'b0;
      pmod_latch <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (go) begin
          shift_reg <= buttons;
          bit_cnt   <= BIT_LAST;
          busy      <= 1'b1;
          state     <= LOW;
        end
        LOW: if (tc) begin
          pmod_clk <= 1'b1;
          state    <= HIGH;
        end
        HIGH: if (tc) begin
          // The final shift empties the register, which drives data low for LATCH/GAP.
          pmod_clk  <= 1'b0;
          shift_reg <= shift_reg << 1;
          if (last_bit) begin
            pmod_latch <= 1'b1;
            frame_done <= (LATCH_CYC == 1);
            state      <= LATCH;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
            state   <= LOW;
          end
        end
        LATCH: begin
          if (tc) begin
            pmod_latch <= 1'b0;
            if (GAP_CYC == 0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= GAP;
            end
          end else begin
            frame_done <= (count == CW'(1));
          end
        end
        GAP: if (tc) begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// Bench for gamepad_pmod_tx: two instances (1 controller/default timing, 2 controllers/fast auto)
// compared every cycle against a frame-position model plus a behavioural PMOD receiver.
module tb_gamepad_pmod_tx;
  import gamepad_pmod_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [11:0] btn1;
  logic [23:0] btn2;
  logic        auto1, start1, auto2, start2;
  logic        data1, pclk1, latch1, busy1, done1;
  logic        data2, pclk2, latch2, busy2, done2;

  gamepad_pmod_tx #(.NUM_CTRL(1), .HALF_DIV(4), .LATCH_CYC(4), .GAP_CYC(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .buttons(btn1), .auto_en(auto1), .start(start1),
    .pmod_data(data1), .pmod_clk(pclk1), .pmod_latch(latch1), .busy(busy1), .frame_done(done1)
  );

  gamepad_pmod_tx #(.NUM_CTRL(2), .HALF_DIV(1), .LATCH_CYC(4), .GAP_CYC(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .buttons(btn2), .auto_en(auto2), .start(start2),
    .pmod_data(data2), .pmod_clk(pclk2), .pmod_latch(latch2), .busy(busy2), .frame_done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncomp = 0;
  int nfail = 0;
  int e = 0;
  int hd [2], nb [2], lc [2], gc [2], pp [2];
  int acc [2], rises [2], nlat [2], lat_t [2], done_e [2], bf_e [2], lw [2], lastlw [2];
  logic [23:0] snap [2], rx_sh [2];
  logic [4:0]  pv [2], prevp [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncomp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected {data, clk, latch, busy, done} at frame position n (n=1 is the cycle after acceptance).
  function automatic logic [4:0] exp_pins(input int n, input int h, input int b, input int l,
                                          input int g, input logic [23:0] s);
    logic [4:0] r;
    int fl, k;
    r  = '0;
    fl = 2 * h * b;
    if (n >= 1 && n <= fl + l + g) r[1] = 1'b1;
    if (n >= 1 && n <= fl) begin
      k    = n - 1;
      r[4] = s[b - 1 - k / (2 * h)];
      r[3] = (k % (2 * h)) >= h;
    end else if (n > fl && n <= fl + l) begin
      r[2] = 1'b1;
      r[0] = (n == fl + l);
    end
    return r;
  endfunction

  task automatic cyc();
    logic        go [2];
    logic [23:0] bin [2];
    logic        rcap;
    logic [23:0] m;
    go[0]  = start1 | auto1;
    go[1]  = start2 | auto2;
    bin[0] = 24'(btn1);
    bin[1] = btn2;
    rcap   = rst_n;
    @(posedge clk);
    e++;
    for (int d = 0; d < 2; d++) begin
      if (!rcap) acc[d] = -100000;
      else if (go[d] && e >= acc[d] + pp[d]) begin
        acc[d]  = e;
        snap[d] = bin[d];
      end
    end
    #1;
    pv[0] = {data1, pclk1, latch1, busy1, done1};
    pv[1] = {data2, pclk2, latch2, busy2, done2};
    for (int d = 0; d < 2; d++) begin
      chk(d == 0 ? "pins1" : "pins2", 32'(pv[d]),
          32'(exp_pins(e - acc[d] + 1, hd[d], nb[d], lc[d], gc[d], snap[d])));
      if (pv[d][3] && !prevp[d][3]) begin
        rx_sh[d] = {rx_sh[d][22:0], pv[d][4]};
        rises[d]++;
      end
      if (pv[d][2] && !prevp[d][2]) begin
        m = (nb[d] == 24) ? 24'hFFFFFF : 24'h000FFF;
        chk("rises_per_frame", 32'(rises[d]), 32'(nb[d]));
        chk("rx_commit", 32'(rx_sh[d] & m), 32'(snap[d] & m));
        rises[d] = 0;
        lat_t[d] = e;
        nlat[d]++;
      end
      if (pv[d][2]) lw[d]++;
      else if (prevp[d][2]) begin
        lastlw[d] = lw[d];
        lw[d]     = 0;
      end
      if (pv[d][0]) done_e[d] = e;
      if (prevp[d][1] && !pv[d][1]) bf_e[d] = e;
      prevp[d] = pv[d];
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_done(input int d, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      cyc();
      if (pv[d][0]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int a0, base, prev_t;
    bit ok;
    logic [11:0] exp12;
    hd[0] = 4; nb[0] = BTN_PER_CTRL;     lc[0] = 4; gc[0] = 16;
    hd[1] = 1; nb[1] = 2 * BTN_PER_CTRL; lc[1] = 4; gc[1] = 0;
    for (int d = 0; d < 2; d++) begin
      pp[d]  = 1 + 2 * hd[d] * nb[d] + lc[d] + gc[d];
      acc[d] = -100000; rises[d] = 0; nlat[d] = 0; lat_t[d] = 0; done_e[d] = 0;
      bf_e[d] = 0; lw[d] = 0; lastlw[d] = 0; snap[d] = '0; rx_sh[d] = '0; prevp[d] = '0;
    end
    btn1 = '0; btn2 = '0; auto1 = 0; start1 = 0; auto2 = 0; start2 = 0;

    // reset state
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    chk("reset_pins1", 32'({data1, pclk1, latch1, busy1, done1}), 32'd0);
    chk("reset_pins2", 32'({data2, pclk2, latch2, busy2, done2}), 32'd0);
    run(2);
    rst_n = 1'b1;
    run(3);

    // directed single frame, start while busy, buttons changed mid-frame
    btn1 = 12'h801; start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    a0   = acc[0];
    base = nlat[0];
    for (int i = 2; i <= 130; i++) begin
      start1 = (i == 20);
      if (i == 30) btn1 = 12'($urandom);
      cyc();
    end
    start1 = 1'b0;
    chk("single_latches", 32'(nlat[0] - base), 32'd1);
    chk("done_cycle", 32'(done_e[0] - a0 + 1), 32'd100);
    chk("busy_low_cycle", 32'(bf_e[0] - a0 + 1), 32'd117);
    chk("latch_width", 32'(lastlw[0]), 32'd4);
    exp12 = 12'h801;
    for (int i = 11; i >= 0; i--) chk("sampled_bit", 32'(rx_sh[0][i]), 32'(exp12[i]));

    // randomized starts and button changes
    for (int i = 0; i < 600; i++) begin
      start1 = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 7) == 0) btn1 = 12'($urandom);
      cyc();
    end
    start1 = 1'b0;
    run(130);

    // start and auto_en together for one cycle
    base = nlat[0];
    start1 = 1'b1; auto1 = 1'b1;
    cyc();
    start1 = 1'b0; auto1 = 1'b0;
    run(200);
    chk("start_auto_one_frame", 32'(nlat[0] - base), 32'd1);

    // auto-mode walking one through every button
    btn1   = 12'(1) << BTN_B;
    auto1  = 1'b1;
    prev_t = 0;
    for (int i = 0; i < 12; i++) begin
      wait_done(0, ok);
      chk("walk_done_seen", 32'(ok), 32'd1);
      exp12 = 12'h800 >> i;
      chk("walk_commit", 32'(rx_sh[0][11:0]), 32'(exp12));
      if (i > 0) chk("walk_period", 32'(lat_t[0] - prev_t), 32'd117);
      prev_t = lat_t[0];
      btn1   = exp12 >> 1;
    end
    base = nlat[0];
    run(50);
    auto1 = 1'b0;
    run(250);
    chk("auto_drop_frames", 32'(nlat[0] - base), 32'd1);
    chk("auto_drop_busy", 32'(busy1), 32'd0);

    // two controllers, fast auto timing without gap
    btn2 = {12'hA5A, 12'h3C3};
    auto2 = 1'b1; start2 = 1'b1;
    cyc();
    start2 = 1'b0;
    prev_t = 0;
    for (int i = 0; i < 4; i++) begin
      wait_done(1, ok);
      chk("dual_done_seen", 32'(ok), 32'd1);
      chk("dual_rx_view", 32'(rx_sh[1][11:0]), 32'h3C3);
      chk("dual_ctrl1", 32'(rx_sh[1][23:12]), 32'hA5A);
      if (i > 0) chk("dual_period", 32'(lat_t[1] - prev_t), 32'd53);
      prev_t = lat_t[1];
    end
    base = nlat[1];
    run(20);
    auto2 = 1'b0;
    run(120);
    chk("dual_drop_frames", 32'(nlat[1] - base), 32'd1);

    // reset during bit 5 HIGH, then a clean frame
    btn1 = 12'($urandom); start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    run(45);
    chk("pclk_high_bit5", 32'(pclk1), 32'd1);
    base = nlat[0];
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_pins", 32'({data1, pclk1, latch1, busy1, done1}), 32'd0);
    rises[0] = 0;
    rises[1] = 0;
    run(3);
    rst_n = 1'b1;
    cyc();
    chk("no_latch_on_abort", 32'(nlat[0] - base), 32'd0);
    btn1 = 12'($urandom); start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    run(130);
    chk("clean_frame_after_reset", 32'(nlat[0] - base), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
